// File: rtl/serial_sub_pkg.sv
// ---------------------------------------------------------------------------
// serial_sub_pkg
//
// Purpose : Shared type for the bit-serial subtractor. It holds the FSM state
//           encoding used by serial_subtractor.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } serial_sub_state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// ---------------------------------------------------------------------------
// full_subtractor
//
// Purpose : One-bit full-subtractor cell. It computes a - b - bin and
//           returns the difference bit and the borrow-out.
// Ports   : a    - minuend bit
//           b    - subtrahend bit
//           bin  - borrow-in
//           d    - difference bit
//           bout - borrow-out
// ---------------------------------------------------------------------------
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   // A borrow is generated when a=0,b=1. When a==b, an incoming borrow is
   // passed through to the output.
   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Purpose : Bit-serial N-bit subtractor. It computes Diff = A - B - Bin,
//           LSB first, one bit per clock, through a single full-subtractor
//           cell. Operands and results use a valid/ready handshake.
// Ports   : clk       - clock, rising edge
//           reset     - synchronous, active-high reset
//           in_valid  - operands A, B, Bin present
//           in_ready  - block can accept operands (IDLE only)
//           A, B      - unsigned minuend / subtrahend, N bits
//           Bin       - borrow-in
//           out_valid - Diff/Bout valid (DONE only)
//           out_ready - consumer accepts the result
//           Diff      - (A - B - Bin) mod 2^N
//           Bout      - borrow-out, 1 iff A < B + Bin
//           Z, V      - zero / signed-overflow flags (optional)
// Config  : define SERIAL_SUB_FLAGS_EN to add the registered Z and V outputs.
// ---------------------------------------------------------------------------
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         Bin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] Diff,
   output logic         Bout
`ifdef SERIAL_SUB_FLAGS_EN
   ,
   output logic         Z,
   output logic         V
`endif
);

   localparam int CW = $clog2(N + 1);

   serial_sub_state_t stateQ, stateD;
   logic [N-1:0]      aShQ, aShD;
   logic [N-1:0]      bShQ, bShD;
   logic [N-1:0]      resQ, resD;
   logic              borrowQ, borrowD;
   logic [CW-1:0]     countQ, countD;
   logic              fsD;
   logic              fsBout;

`ifdef SERIAL_SUB_FLAGS_EN
   logic              aMsbQ, aMsbD;
   logic              bMsbQ, bMsbD;
   logic              zQ, zD;
   logic              vQ, vD;
`endif

   // Single arithmetic cell. It is fed from the LSBs of the operand shift
   // registers and the running borrow.
   full_subtractor uFs (
      .a   (aShQ[0]),
      .b   (bShQ[0]),
      .bin (borrowQ),
      .d   (fsD),
      .bout(fsBout)
   );

   // The result register and the borrow drive the outputs directly. They
   // only change during RUN, so they hold steady across DONE and the
   // following IDLE until the next accepted transaction.
   assign Diff = resQ;
   assign Bout = borrowQ;
`ifdef SERIAL_SUB_FLAGS_EN
   assign Z    = zQ;
   assign V    = vQ;
`endif

   // State and datapath registers. Reset clears everything, so any
   // transaction in flight is abandoned without emitting a result.
   always_ff @(posedge clk) begin
      if (reset) begin
         stateQ  <= IDLE;
         aShQ    <= '0;
         bShQ    <= '0;
         resQ    <= '0;
         borrowQ <= 1'b0;
         countQ  <= '0;
`ifdef SERIAL_SUB_FLAGS_EN
         aMsbQ   <= 1'b0;
         bMsbQ   <= 1'b0;
         zQ      <= 1'b0;
         vQ      <= 1'b0;
`endif
      end else begin
         stateQ  <= stateD;
         aShQ    <= aShD;
         bShQ    <= bShD;
         resQ    <= resD;
         borrowQ <= borrowD;
         countQ  <= countD;
`ifdef SERIAL_SUB_FLAGS_EN
         aMsbQ   <= aMsbD;
         bMsbQ   <= bMsbD;
         zQ      <= zD;
         vQ      <= vD;
`endif
      end
   end

   // Next-state and handshake logic. Every register holds by default. IDLE
   // loads the operands. RUN shifts one bit per cycle, and each new
   // difference bit enters at the MSB of the result register. DONE waits
   // for the consumer to take the result.
   always_comb begin
      stateD    = stateQ;
      aShD      = aShQ;
      bShD      = bShQ;
      resD      = resQ;
      borrowD   = borrowQ;
      countD    = countQ;
      in_ready  = 1'b0;
      out_valid = 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
      aMsbD     = aMsbQ;
      bMsbD     = bMsbQ;
      zD        = zQ;
      vD        = vQ;
`endif

      case (stateQ)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               aShD    = A;
               bShD    = B;
               borrowD = Bin;
               countD  = '0;
               stateD  = RUN;
`ifdef SERIAL_SUB_FLAGS_EN
               aMsbD   = A[N-1];
               bMsbD   = B[N-1];
`endif
            end
         end

         RUN: begin
            aShD         = aShQ >> 1;
            bShD         = bShQ >> 1;
            resD         = resQ >> 1;
            resD[N-1]    = fsD;
            borrowD      = fsBout;
            if (countQ == CW'(N - 1)) begin
               stateD = DONE;
`ifdef SERIAL_SUB_FLAGS_EN
               zD     = (resD == '0);
               vD     = (aMsbQ != bMsbQ) && (resD[N-1] != aMsbQ);
`endif
            end else begin
               countD = countQ + CW'(1);
            end
         end

         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               stateD = IDLE;
            end
         end

         default: begin
            stateD = IDLE;
         end
      endcase
   end

endmodule
